// File: rtl/fft_frame_collector.sv
// Ping-pong frame collector between the filter output and the FFT input.
// Optional build macro FFT_COLLECT_BITREV_EN replays each frame in bit-reversed address order.
module fft_frame_collector #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_last,
  output logic              frame_done,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_PTR = LOG2N'(N - 1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  logic [DATA_W-1:0] mem_q [2][N];

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [LOG2N-1:0]  wr_ptr_q, wr_ptr_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]        full_q, full_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_count_q, drop_count_d;

  logic              wr_en;
  logic              drop;
  logic              xfer;
  logic              last_xfer;
  logic [LOG2N-1:0]  addr;

`ifdef FFT_COLLECT_BITREV_EN
  always_comb begin
    addr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      addr[i] = rd_ptr_q[LOG2N-1-i];
    end
  end
`else
  assign addr = rd_ptr_q;
`endif

  // Write side and read FSM share the full flags, so both live in one next-state process.
  always_comb begin
    state_d      = state_q;
    wr_bank_d    = wr_bank_q;
    wr_ptr_d     = wr_ptr_q;
    rd_bank_d    = rd_bank_q;
    rd_ptr_d     = rd_ptr_q;
    full_d       = full_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    wr_en        = in_valid && !full_q[wr_bank_q];
    drop         = in_valid && full_q[wr_bank_q];
    xfer         = (state_q == READ) && out_ready;
    last_xfer    = xfer && (rd_ptr_q == LAST_PTR);
    frame_done_d = last_xfer;

    if (wr_en) begin
      if (wr_ptr_q == LAST_PTR) begin
        full_d[wr_bank_q] = 1'b1;
        wr_ptr_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != {DROP_W{1'b1}}) begin
        drop_count_d = drop_count_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = READ;
        end
      end
      READ: begin
        if (last_xfer) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_ptr_d          = '0;
          state_d           = IDLE;
        end else if (xfer) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_bank_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_ptr_q     <= '0;
      full_q       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_bank_q    <= wr_bank_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_bank_q    <= rd_bank_d;
      rd_ptr_q     <= rd_ptr_d;
      full_q       <= full_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Frame RAM is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_ptr_q] <= in_data;
    end
  end

  assign out_valid  = (state_q == READ);
  assign out_data   = mem_q[rd_bank_q][addr];
  assign out_index  = addr;
  assign out_last   = (state_q == READ) && (rd_ptr_q == LAST_PTR);
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fft_frame_collector.sv
// Scoreboard bench for fft_frame_collector: a frame-level model predicts replayed samples,
// drops and frame_done pulses; a negedge monitor compares them against the DUT.
module tb_fft_frame_collector;

  localparam int DATA_W = 32;
  localparam int LOG2N  = 4;
  localparam int DROP_W = 16;
  localparam int N      = 1 << LOG2N;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LOG2N-1:0]  index;
    logic              last;
  } exp_t;

  logic              clk       = 1'b0;
  logic              rst       = 1'b1;
  logic              in_valid  = 1'b0;
  logic [DATA_W-1:0] in_data   = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [LOG2N-1:0]  out_index;
  logic              out_last;
  logic              frame_done;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] fill_q[$];
  int                held        = 0;
  int                model_drops = 0;
  logic              model_ovf   = 1'b0;
  logic              expect_fd   = 1'b0;
  int                n_checks    = 0;
  int                n_fail      = 0;

  fft_frame_collector #(
    .DATA_W(DATA_W),
    .LOG2N (LOG2N),
    .DROP_W(DROP_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .frame_done(frame_done),
    .overflow  (overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic int replay_addr(input int k);
`ifdef FFT_COLLECT_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      if (((k >> b) & 1) != 0) r = r | (1 << (LOG2N - 1 - b));
    end
    return r;
`else
    return k;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  // The model holds at most two completed frames; a sample is accepted only while fewer
  // than two are held, judged on the state before the edge that would capture it.
  always @(negedge clk) begin
    int   held_pre;
    exp_t e;
    checkOutput("frame_done", 64'(frame_done), 64'(expect_fd));
    checkOutput("drop_count", 64'(drop_count), 64'(model_drops));
    checkOutput("overflow", 64'(overflow), 64'(model_ovf));
    expect_fd = 1'b0;
    if (rst) begin
      exp_q.delete();
      fill_q.delete();
      held        = 0;
      model_drops = 0;
      model_ovf   = 1'b0;
    end else begin
      held_pre = held;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("spurious_out_valid", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q[0];
          checkOutput("out_data", 64'(out_data), 64'(e.data));
          checkOutput("out_index", 64'(out_index), 64'(e.index));
          checkOutput("out_last", 64'(out_last), 64'(e.last));
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (e.last) begin
              held--;
              expect_fd = 1'b1;
            end
          end
        end
      end
      if (in_valid) begin
        if (held_pre < 2) begin
          fill_q.push_back(in_data);
          if (fill_q.size() == N) begin
            for (int k = 0; k < N; k++) begin
              e.data  = fill_q[replay_addr(k)];
              e.index = LOG2N'(replay_addr(k));
              e.last  = (k == N - 1);
              exp_q.push_back(e);
            end
            held++;
            fill_q.delete();
          end
        end else begin
          model_ovf = 1'b1;
          if (model_drops < (1 << DROP_W) - 1) model_drops++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int cycles;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      applyStimulus(1'b0, '0, 1'b1);
      cycles++;
    end
    checkOutput("drain_timeout", 64'(exp_q.size()), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_last", 64'(out_last), 64'd0);

    $display("[TB] single frame, natural order");
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DATA_W'(i), 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("valid_at_last_write", 64'(out_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("valid_one_clk_later", 64'(out_valid), 64'd1);
    drain(100);

    $display("[TB] continuous 48 samples");
    for (int i = 0; i < 48; i++) applyStimulus(1'b1, DATA_W'(200 + i), 1'b1);
    drain(200);
    pulseReset();

    $display("[TB] back-pressure with drops");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("drop_count_eight", 64'(drop_count), 64'd8);
    checkOutput("overflow_sticky", 64'(overflow), 64'd1);
    checkOutput("held_sample0", 64'(out_data), 64'd0);
    drain(200);

    $display("[TB] toggling out_ready");
    for (int i = 0; i < 64; i++) applyStimulus((i % 2) == 0, DATA_W'(300 + i), (i % 2) == 1);
    drain(200);
    pulseReset();
    checkOutput("overflow_cleared", 64'(overflow), 64'd0);

    $display("[TB] reset during readout");
    for (int i = 0; i < N + 7; i++) applyStimulus(1'b1, DATA_W'(400 + i), 1'b1);
    pulseReset();
    checkOutput("valid_after_reset", 64'(out_valid), 64'd0);
    checkOutput("drops_after_reset", 64'(drop_count), 64'd0);
    for (int i = 0; i < N; i++) applyStimulus(1'b1, DATA_W'(100 + i), 1'b1);
    drain(100);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
    end
    drain(300);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
